mat3_mult_ctrl: RTL and testbench
=================================

MAT3_MULT_CTRL -- requirements
Module: mat3_mult_ctrl

Interface
REQ-001 SHALL have parameter ACC_W, default 18, giving the accumulator and result width; legal values are 18 or more.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, a request to compute C = A x B for 3x3 signed 8-bit matrices.
REQ-005 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-006 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-007 SHALL have ports a_addr and b_addr, output, 4 each, element indices (row*3+col) into the external A and B stores.
REQ-008 SHALL have ports a_data and b_data, input, 8 each, signed elements returned combinationally in the same cycle as the address.
REQ-009 SHALL have ports mul_a and mul_b (output, 8 each), mul_load (output, 1) and mul_m (input, 16), connecting to one multi8_8 instance.
REQ-010 SHALL have ports c_we (output, 1), c_addr (output, 4) and c_data (output, ACC_W, signed), the result-store write port.

Function
REQ-011 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-012 SHALL, in IDLE with start=1, go to RUN and clear the counters i, j and k; start in any other state SHALL be ignored.
REQ-013 SHALL, in RUN, each cycle drive a_addr=i*3+k and b_addr=k*3+j, mul_a=a_data, mul_b=b_data and mul_load=1.
REQ-014 SHALL, in RUN, advance k each cycle; when k wraps 2->0, advance j; when j wraps 2->0, advance i.
REQ-015 SHALL go from RUN to DRAIN after issuing (i,j,k)=(2,2,2), which is 27 issue cycles in total.
REQ-016 SHALL hold mul_load=0 outside RUN; mul_a, mul_b, a_addr and b_addr are don't-care while mul_load=0.
REQ-017 SHALL treat mul_m as valid exactly one cycle after the cycle in which its operands were loaded, because multi8_8 registers its partial products.
REQ-018 SHALL carry a valid flag plus the i, j and k tags through one pipeline stage, aligned with mul_m.
REQ-019 SHALL, on a valid cycle, set acc_next = sext(mul_m) if tag k=0, else acc + sext(mul_m); arithmetic is signed, width ACC_W, with no saturation.
REQ-020 SHALL, on a valid cycle with tag k=2, register c_we=1, c_addr=i*3+j and c_data=acc_next; c_we SHALL fall the following cycle unless another write is due.
REQ-021 SHALL write C elements in order 0..8, each exactly once, at a rate of one write per 3 cycles.
REQ-022 SHALL go from DRAIN to DONE in the cycle in which the write for c_addr=8 is asserted, and from DONE to IDLE after exactly one cycle.
REQ-023 SHALL set busy=1 in RUN, DRAIN and DONE, and done=1 only in DONE.
REQ-024 SHALL meet this timing, with start sampled in IDLE in cycle 0:
- issue cycles are 1..27;
- element n is written in cycle 3n+5;
- the final write is in cycle 29;
- done is high in cycle 30;
- busy is high in cycles 1..30.
REQ-025 SHALL, if start=1 in the DONE cycle, ignore it; a start held high in the following IDLE cycle SHALL be accepted.
REQ-026 SHALL produce a worst-case magnitude of 3 x 16384 = 49152, which fits 18-bit signed, so no overflow occurs.

Reset
REQ-027 SHALL, while rst_n=0 (asynchronously), set the state to IDLE, i=j=k=0, the valid flag to 0 and acc to 0, and drive busy=0, done=0, mul_load=0, c_we=0, c_addr=0 and c_data=0.
REQ-028 SHALL, on reset mid-operation, abandon the operation with no further c_we; the multiplier register is not reset, so the valid flag alone gates use of mul_m.
REQ-029 SHALL wait at least one cycle with rst_n=1 after release before accepting start.

Verification
REQ-030 SHALL cover: A = identity, B[n]=n-4 -> c_data on writes 0..8 equals -4..4 in order; done in cycle 30.
REQ-031 SHALL cover: A = B = all -128 -> all nine writes give c_data = 49152 (18'sh0C000).
REQ-032 SHALL cover: A all 127, B all -128 -> all nine writes give -48768.
REQ-033 SHALL cover: 100 random matrix pairs compared to a reference model -> exact match, 9 writes per run, the c_addr sequence 0..8, and c_we spacing of 3 cycles.
REQ-034 SHALL cover: start pulsed in cycle 10 of a run, and start=1 in the DONE cycle -> no restart and no extra writes; with start held, the second run's first issue occurs in the cycle after IDLE is entered.
REQ-035 SHALL cover: rst_n pulled low in cycle 14 -> busy, c_we and mul_load drop to 0 immediately; a new start then gives a correct full result.

Source files
------------

// File: rtl/mat3_mult_ctrl.sv
// Sequencer for C = A x B on 3x3 signed 8-bit matrices using one external registered multiplier.
// 27 issue cycles, products tagged through one stage to the accumulator; C[n] written in cycle 3n+5, done in cycle 30.
module mat3_mult_ctrl #(
  parameter int ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              a_addr,
  output logic [3:0]              b_addr,
  input  logic signed [7:0]       a_data,
  input  logic signed [7:0]       b_data,
  output logic signed [7:0]       mul_a,
  output logic signed [7:0]       mul_b,
  output logic                    mul_load,
  input  logic signed [15:0]      mul_m,
  output logic                    c_we,
  output logic [3:0]              c_addr,
  output logic signed [ACC_W-1:0] c_data
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [1:0]              r_i, r_j, r_k;
  logic [1:0]              w_i_nxt, w_j_nxt, w_k_nxt;
  logic                    r_vld;
  logic [1:0]              r_ti, r_tj, r_tk;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic                    r_c_we;
  logic [3:0]              r_c_addr;
  logic signed [ACC_W-1:0] r_c_data;

  assign a_addr = {2'b00, r_i} * 4'd3 + {2'b00, r_k};
  assign b_addr = {2'b00, r_k} * 4'd3 + {2'b00, r_j};
  assign mul_a  = a_data;
  assign mul_b  = b_data;

  assign w_prod    = {{(ACC_W-16){mul_m[15]}}, mul_m};
  assign w_acc_nxt = (r_tk == 2'd0) ? w_prod : r_acc + w_prod;

  assign c_we   = r_c_we;
  assign c_addr = r_c_addr;
  assign c_data = r_c_data;

  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_k_nxt     = r_k;
    busy        = 1'b0;
    done        = 1'b0;
    mul_load    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_i_nxt     = 2'd0;
          w_j_nxt     = 2'd0;
          w_k_nxt     = 2'd0;
        end
      end
      RUN: begin
        busy     = 1'b1;
        mul_load = 1'b1;
        // k fastest, then j, then i; leaving after (2,2,2) is issued
        if (r_k == 2'd2) begin
          w_k_nxt = 2'd0;
          if (r_j == 2'd2) begin
            w_j_nxt = 2'd0;
            if (r_i == 2'd2) begin
              w_i_nxt     = 2'd0;
              w_state_nxt = DRAIN;
            end else begin
              w_i_nxt = r_i + 2'd1;
            end
          end else begin
            w_j_nxt = r_j + 2'd1;
          end
        end else begin
          w_k_nxt = r_k + 2'd1;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (r_c_we && r_c_addr == 4'd8) w_state_nxt = DONE;
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_i     <= 2'd0;
      r_j     <= 2'd0;
      r_k     <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
      r_j     <= w_j_nxt;
      r_k     <= w_k_nxt;
    end
  end

  // The multiplier register is never reset, so r_vld alone decides whether mul_m is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld    <= 1'b0;
      r_ti     <= 2'd0;
      r_tj     <= 2'd0;
      r_tk     <= 2'd0;
      r_acc    <= '0;
      r_c_we   <= 1'b0;
      r_c_addr <= 4'd0;
      r_c_data <= '0;
    end else begin
      r_vld  <= mul_load;
      r_ti   <= r_i;
      r_tj   <= r_j;
      r_tk   <= r_k;
      r_c_we <= r_vld && (r_tk == 2'd2);
      if (r_vld) r_acc <= w_acc_nxt;
      if (r_vld && r_tk == 2'd2) begin
        r_c_addr <= {2'b00, r_ti} * 4'd3 + {2'b00, r_tj};
        r_c_data <= w_acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mat3_mult_ctrl.sv
// Directed and random bench for mat3_mult_ctrl with a behavioural registered 8x8 multiplier and A/B stores.
module tb_mat3_mult_ctrl;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               busy, done;
  logic [3:0]         a_addr, b_addr;
  logic signed [7:0]  a_data, b_data;
  logic signed [7:0]  mul_a, mul_b;
  logic               mul_load;
  logic signed [15:0] mul_m;
  logic               c_we;
  logic [3:0]         c_addr;
  logic signed [17:0] c_data;

  logic signed [7:0]  A [9];
  logic signed [7:0]  B [9];

  int n_checks;
  int n_pass;
  int exp_c [9];
  int wr_cyc[$];
  int wr_addr[$];
  int wr_dat[$];
  int done_cyc;
  int busy_errs;
  int issue2;

  mat3_mult_ctrl #(.ACC_W(18)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .a_addr   (a_addr),
    .b_addr   (b_addr),
    .a_data   (a_data),
    .b_data   (b_data),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_load (mul_load),
    .mul_m    (mul_m),
    .c_we     (c_we),
    .c_addr   (c_addr),
    .c_data   (c_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign a_data = (a_addr < 4'd9) ? A[a_addr] : 8'sd0;
  assign b_data = (b_addr < 4'd9) ? B[b_addr] : 8'sd0;

  always @(posedge clk) begin
    if (mul_load) mul_m <= mul_a * mul_b;
  end

  // Start in cycle 0, then sample every cycle mid-period; start can be re-pulsed or held across DONE.
  task automatic run_capture(input int ncyc, input int pulse_cyc, input bit hold_into_idle);
    wr_cyc.delete();
    wr_addr.delete();
    wr_dat.delete();
    done_cyc  = -1;
    busy_errs = 0;
    issue2    = -1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        exp_c[r*3+c] = 0;
        for (int k = 0; k < 3; k++)
          exp_c[r*3+c] += int'(A[r*3+k]) * int'(B[k*3+c]);
      end
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      if (c_we) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(int'(c_addr));
        wr_dat.push_back(int'(c_data));
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (cyc <= 31 && busy !== (cyc <= 30)) busy_errs++;
      if (mul_load && cyc > 30 && issue2 < 0) issue2 = cyc;
      start = (cyc == pulse_cyc) || (hold_into_idle && (cyc == 30 || cyc == 31));
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    #12;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
    n_checks++; if (mul_load !== 1'b0) $display("FAIL rst_mul_load: got %b want 0", mul_load); else n_pass++;
    n_checks++; if (c_we !== 1'b0) $display("FAIL rst_c_we: got %b want 0", c_we); else n_pass++;
    n_checks++; if (c_addr !== 4'd0) $display("FAIL rst_c_addr: got %0d want 0", c_addr); else n_pass++;
    n_checks++; if (c_data !== 18'sd0) $display("FAIL rst_c_data: got %0d want 0", c_data); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_identity();
    for (int n = 0; n < 9; n++) begin
      A[n] = (n == 0 || n == 4 || n == 8) ? 8'sd1 : 8'sd0;
      B[n] = 8'(n - 4);
    end
    run_capture(32, -1, 1'b0);
    n_checks++;
    if (wr_cyc.size() != 9) $display("FAIL id_count: got %0d writes want 9", wr_cyc.size()); else n_pass++;
    for (int n = 0; n < 9; n++) begin
      n_checks++;
      if (n >= wr_cyc.size())
        $display("FAIL id_elem%0d: write missing", n);
      else if (wr_addr[n] != n || wr_dat[n] != n - 4 || wr_cyc[n] != 3*n + 5)
        $display("FAIL id_elem%0d: cyc=%0d addr=%0d data=%0d want cyc=%0d addr=%0d data=%0d",
                 n, wr_cyc[n], wr_addr[n], wr_dat[n], 3*n + 5, n, n - 4);
      else n_pass++;
    end
    n_checks++; if (done_cyc != 30) $display("FAIL id_done_cycle: got %0d want 30", done_cyc); else n_pass++;
    n_checks++; if (busy_errs != 0) $display("FAIL id_busy_window: %0d bad cycles want 0", busy_errs); else n_pass++;
  endtask

  task automatic test_extremes();
    int want [2];
    want[0] = 49152;
    want[1] = -48768;
    for (int p = 0; p < 2; p++) begin
      for (int n = 0; n < 9; n++) begin
        A[n] = (p == 0) ? -8'sd128 : 8'sd127;
        B[n] = -8'sd128;
      end
      run_capture(32, -1, 1'b0);
      n_checks++;
      if (wr_cyc.size() != 9) $display("FAIL ext%0d_count: got %0d writes want 9", p, wr_cyc.size()); else n_pass++;
      for (int n = 0; n < 9; n++) begin
        n_checks++;
        if (n >= wr_cyc.size())
          $display("FAIL ext%0d_elem%0d: write missing", p, n);
        else if (wr_addr[n] != n || wr_dat[n] != want[p])
          $display("FAIL ext%0d_elem%0d: addr=%0d data=%0d want addr=%0d data=%0d",
                   p, n, wr_addr[n], wr_dat[n], n, want[p]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    int bad_seq, bad_dat;
    for (int run = 0; run < 100; run++) begin
      for (int n = 0; n < 9; n++) begin
        A[n] = 8'($urandom_range(0, 255));
        B[n] = 8'($urandom_range(0, 255));
      end
      run_capture(32, -1, 1'b0);
      bad_seq = 0;
      bad_dat = 0;
      for (int n = 0; n < wr_cyc.size() && n < 9; n++) begin
        if (wr_addr[n] != n) bad_seq++;
        if (n > 0 && wr_cyc[n] - wr_cyc[n-1] != 3) bad_seq++;
        if (wr_dat[n] != exp_c[n]) bad_dat++;
      end
      n_checks++;
      if (wr_cyc.size() != 9) $display("FAIL rnd%0d_count: got %0d writes want 9", run, wr_cyc.size()); else n_pass++;
      n_checks++;
      if (bad_seq != 0) $display("FAIL rnd%0d_addr_spacing: %0d errors want 0", run, bad_seq); else n_pass++;
      n_checks++;
      if (bad_dat != 0) $display("FAIL rnd%0d_data: %0d mismatching elements want 0", run, bad_dat); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int n_first;
    for (int n = 0; n < 9; n++) begin
      A[n] = 8'(n * 7 - 30);
      B[n] = 8'(50 - n * 11);
    end
    run_capture(65, 10, 1'b1);
    n_first = 0;
    foreach (wr_cyc[q]) if (wr_cyc[q] <= 35) n_first++;
    n_checks++; if (n_first != 9) $display("FAIL b2b_first_run_writes: got %0d want 9", n_first); else n_pass++;
    n_checks++; if (done_cyc != 30) $display("FAIL b2b_done_cycle: got %0d want 30", done_cyc); else n_pass++;
    n_checks++; if (busy_errs != 0) $display("FAIL b2b_busy_window: %0d bad cycles want 0", busy_errs); else n_pass++;
    n_checks++; if (issue2 != 32) $display("FAIL b2b_second_issue: got cycle %0d want 32", issue2); else n_pass++;
    n_checks++; if (wr_cyc.size() != 18) $display("FAIL b2b_total_writes: got %0d want 18", wr_cyc.size()); else n_pass++;
    for (int n = 0; n < 9 && wr_cyc.size() == 18; n++) begin
      n_checks++;
      if (wr_cyc[n+9] != 3*n + 36 || wr_addr[n+9] != n || wr_dat[n+9] != exp_c[n] || wr_dat[n] != exp_c[n])
        $display("FAIL b2b_elem%0d: cyc=%0d addr=%0d data=%0d want cyc=%0d addr=%0d data=%0d",
                 n, wr_cyc[n+9], wr_addr[n+9], wr_dat[n+9], 3*n + 36, n, exp_c[n]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic ml_before, we_before;
    int   stray;
    for (int n = 0; n < 9; n++) begin
      A[n] = 8'(9 - n * 5);
      B[n] = 8'(n * 13 - 60);
    end
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    ml_before = mul_load;
    we_before = c_we;
    rst_n = 1'b0;
    #1;
    n_checks++; if (ml_before !== 1'b1 || we_before !== 1'b1)
      $display("FAIL mid_pre_reset: mul_load=%b c_we=%b want 1 1", ml_before, we_before); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (c_we !== 1'b0) $display("FAIL mid_c_we: got %b want 0", c_we); else n_pass++;
    n_checks++; if (mul_load !== 1'b0) $display("FAIL mid_mul_load: got %b want 0", mul_load); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (c_we !== 1'b0 || busy !== 1'b0) stray++;
    end
    n_checks++; if (stray != 0) $display("FAIL mid_no_stray_write: %0d active cycles want 0", stray); else n_pass++;
    run_capture(32, -1, 1'b0);
    n_checks++;
    if (wr_cyc.size() != 9) $display("FAIL mid_rerun_count: got %0d writes want 9", wr_cyc.size()); else n_pass++;
    for (int n = 0; n < 9 && n < wr_cyc.size(); n++) begin
      n_checks++;
      if (wr_addr[n] != n || wr_dat[n] != exp_c[n] || wr_cyc[n] != 3*n + 5)
        $display("FAIL mid_rerun_elem%0d: cyc=%0d addr=%0d data=%0d want cyc=%0d addr=%0d data=%0d",
                 n, wr_cyc[n], wr_addr[n], wr_dat[n], 3*n + 5, n, exp_c[n]);
      else n_pass++;
    end
    n_checks++; if (done_cyc != 30) $display("FAIL mid_rerun_done: got %0d want 30", done_cyc); else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    start    = 1'b0;
    rst_n    = 1'b0;
    for (int n = 0; n < 9; n++) begin
      A[n] = 8'sd0;
      B[n] = 8'sd0;
    end
    test_reset();
    test_identity();
    test_extremes();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
